// File: rtl/video_sprite_eval_if.sv
// ---------------------------------------------------------------------------
// video_sprite_eval_if
//
// Purpose: bundles the scanline request, primary OAM read port, secondary
// OAM write port and the result flags of the sprite evaluator.
//
// Signals:
//   I_start     request pulse, begins evaluation of one scanline
//   I_scanline  target scanline (latched on an accepted start)
//   I_tall      sprite height select, 0 = 8 rows, 1 = 16 rows
//   O_oam_addr  primary OAM read address
//   I_oam_data  primary OAM read data, combinational from O_oam_addr
//   O_sec_addr  secondary OAM write address
//   O_sec_data  secondary OAM write data
//   O_sec_wren  secondary OAM write strobe
//   O_busy      evaluation in progress
//   O_done      one-cycle completion pulse
//   O_count     sprites copied (0..8)
//   O_overflow  a ninth in-range sprite was found
//   O_sprite0   sprite 0 is in range
//
// Modports:
//   master  the requester / memory side (drives the I_* signals)
//   slave   the evaluator itself (drives the O_* signals)
// ---------------------------------------------------------------------------
interface video_sprite_eval_if;
  logic       I_start;
  logic [7:0] I_scanline;
  logic       I_tall;
  logic [7:0] O_oam_addr;
  logic [7:0] I_oam_data;
  logic [4:0] O_sec_addr;
  logic [7:0] O_sec_data;
  logic       O_sec_wren;
  logic       O_busy;
  logic       O_done;
  logic [3:0] O_count;
  logic       O_overflow;
  logic       O_sprite0;

  modport master (
    output I_start, I_scanline, I_tall, I_oam_data,
    input  O_oam_addr, O_sec_addr, O_sec_data, O_sec_wren,
           O_busy, O_done, O_count, O_overflow, O_sprite0
  );

  modport slave (
    input  I_start, I_scanline, I_tall, I_oam_data,
    output O_oam_addr, O_sec_addr, O_sec_data, O_sec_wren,
           O_busy, O_done, O_count, O_overflow, O_sprite0
  );
endinterface

// File: rtl/video_sprite_eval.sv
// ---------------------------------------------------------------------------
// video_sprite_eval
//
// Purpose: per-scanline sprite evaluator. On a start request it clears the
// 32-byte secondary OAM to 0xFF, then walks the 64 primary OAM entries,
// copying the 4 bytes of each sprite whose Y places it on the requested
// scanline, up to 8 sprites. A ninth in-range sprite raises the overflow
// flag and ends the scan immediately.
//
// Ports:
//   I_clock  system clock, rising edge
//   I_reset  asynchronous active-high reset
//   bus      video_sprite_eval_if.slave (request, OAM ports, results)
//
// Cycle cost: start -> 32 CLEAR cycles -> per sprite 1 EVAL cycle, plus
// 3 COPY cycles when the sprite is copied -> 1 DONE cycle.
//
// All bus outputs are decoded combinationally from the registered state so
// that reset forces them to their idle values immediately, without waiting
// for a clock edge.
// ---------------------------------------------------------------------------
module video_sprite_eval (
  input  logic                 I_clock,
  input  logic                 I_reset,
  video_sprite_eval_if.slave   bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_EVAL  = 3'd2;
  localparam logic [2:0] ST_COPY  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [7:0] CLEAR_BYTE = 8'hFF;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [2:0] state_q,    state_d;
  logic [5:0] n_q,        n_d;         // primary OAM sprite index
  logic [4:0] idx_q,      idx_d;       // CLEAR address / COPY byte index
  logic [3:0] count_q,    count_d;     // sprites copied so far
  logic       overflow_q, overflow_d;
  logic       sprite0_q,  sprite0_d;
  logic [7:0] scanline_q, scanline_d;
  logic       tall_q,     tall_d;

  // Combinational bus outputs
  logic [7:0] oam_addr;
  logic [4:0] sec_addr;
  logic [7:0] sec_data;
  logic       sec_wren;

  // ---------------------------------------------------------------------
  // Range test: 9-bit subtraction so a sprite starting below the
  // scanline (Y > scanline) shows up as a set borrow bit rather than a
  // large positive row offset.
  // ---------------------------------------------------------------------
  logic [8:0] diff;
  logic [7:0] height;
  logic       in_range;
  logic       last_sprite;
  logic       sec_full;

  assign diff        = {1'b0, scanline_q} - {1'b0, bus.I_oam_data};
  assign height      = tall_q ? 8'd16 : 8'd8;
  assign in_range    = ~diff[8] && (diff[7:0] < height);
  assign last_sprite = (n_q == 6'd63);
  assign sec_full    = count_q[3];     // count_q == 8

  // ---------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    sprite0_d  = sprite0_q;
    scanline_d = scanline_q;
    tall_d     = tall_q;

    oam_addr   = 8'd0;
    sec_addr   = 5'd0;
    sec_data   = 8'd0;
    sec_wren   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.I_start) begin
          scanline_d = bus.I_scanline;
          tall_d     = bus.I_tall;
          count_d    = 4'd0;
          overflow_d = 1'b0;
          sprite0_d  = 1'b0;
          n_d        = 6'd0;
          idx_d      = 5'd0;
          state_d    = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        sec_wren = 1'b1;
        sec_addr = idx_q;
        sec_data = CLEAR_BYTE;
        if (idx_q == 5'd31) begin
          idx_d   = 5'd0;
          n_d     = 6'd0;
          state_d = ST_EVAL;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end

      ST_EVAL: begin
        oam_addr = {n_q, 2'b00};
        if (in_range && !sec_full) begin
          // The Y byte goes out in the same cycle it is tested, so COPY
          // only has the remaining three bytes to move.
          sec_wren = 1'b1;
          sec_addr = {count_q[2:0], 2'b00};
          sec_data = bus.I_oam_data;
          if (n_q == 6'd0) begin
            sprite0_d = 1'b1;
          end
          idx_d   = 5'd1;
          state_d = ST_COPY;
        end else if (in_range) begin
          // Secondary OAM is already full: this is the ninth hit.
          overflow_d = 1'b1;
          state_d    = ST_DONE;
        end else if (last_sprite) begin
          state_d = ST_DONE;
        end else begin
          n_d = n_q + 6'd1;
        end
      end

      ST_COPY: begin
        oam_addr = {n_q, idx_q[1:0]};
        sec_wren = 1'b1;
        sec_addr = {count_q[2:0], idx_q[1:0]};
        sec_data = bus.I_oam_data;
        if (idx_q[1:0] == 2'd3) begin
          count_d = count_q + 4'd1;
          idx_d   = 5'd0;
          // Sprite 63 finishes its copy and then ends the scan; the
          // index never wraps back to 0.
          if (last_sprite) begin
            state_d = ST_DONE;
          end else begin
            n_d     = n_q + 6'd1;
            state_d = ST_EVAL;
          end
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      state_q    <= ST_IDLE;
      n_q        <= 6'd0;
      idx_q      <= 5'd0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      sprite0_q  <= 1'b0;
      scanline_q <= 8'd0;
      tall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sprite0_q  <= sprite0_d;
      scanline_q <= scanline_d;
      tall_q     <= tall_d;
    end
  end

  // ---------------------------------------------------------------------
  // Bus outputs
  // ---------------------------------------------------------------------
  assign bus.O_oam_addr = oam_addr;
  assign bus.O_sec_addr = sec_addr;
  assign bus.O_sec_data = sec_data;
  assign bus.O_sec_wren = sec_wren;
  assign bus.O_busy     = (state_q != ST_IDLE);
  assign bus.O_done     = (state_q == ST_DONE);
  assign bus.O_count    = count_q;
  assign bus.O_overflow = overflow_q;
  assign bus.O_sprite0  = sprite0_q;

endmodule

// File: tb/tb_video_sprite_eval.sv
// ---------------------------------------------------------------------------
// tb_video_sprite_eval
//
// Self-checking bench for video_sprite_eval. For each scanline request a
// behavioural model walks the primary OAM image and pushes the expected
// secondary-OAM writes onto a queue; every write the DUT makes is popped
// and compared. Final flags, completion latency and the resulting
// secondary OAM image are checked when O_done is seen.
// ---------------------------------------------------------------------------
module tb_video_sprite_eval;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  video_sprite_eval_if bus ();

  video_sprite_eval dut (
    .I_clock (clk),
    .I_reset (rst),
    .bus     (bus)
  );

  // Primary OAM image, read combinationally
  logic [7:0] oam [256];
  assign bus.I_oam_data = oam[bus.O_oam_addr];

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q [$];
  logic [7:0] exp_mem [32];
  logic [7:0] sec_mem [32];
  int         exp_count;
  int         exp_ovf;
  int         exp_s0;
  int         exp_cycles;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Behavioural model: fills exp_q / exp_mem and the expected flags.
  function automatic void build_expect(input int sl, input bit tl);
    wr_t w;
    int  cnt;
    int  cost;
    int  h;
    int  d;
    exp_q.delete();
    for (int a = 0; a < 32; a++) begin
      exp_mem[a] = 8'hFF;
      w.addr = 5'(a);
      w.data = 8'hFF;
      exp_q.push_back(w);
    end
    cnt     = 0;
    cost    = 0;
    exp_ovf = 0;
    exp_s0  = 0;
    h       = tl ? 16 : 8;
    for (int n = 0; n < 64; n++) begin
      d = sl - int'(oam[4*n]);
      if (d >= 0 && d < h) begin
        if (cnt < 8) begin
          for (int k = 0; k < 4; k++) begin
            w.addr = 5'(4*cnt + k);
            w.data = oam[4*n + k];
            exp_mem[4*cnt + k] = oam[4*n + k];
            exp_q.push_back(w);
          end
          if (n == 0) exp_s0 = 1;
          cnt++;
          cost += 4;
        end else begin
          exp_ovf = 1;
          cost += 1;
          break;
        end
      end else begin
        cost += 1;
      end
    end
    exp_count  = cnt;
    exp_cycles = 32 + cost + 1;
  endfunction

  task automatic fill_oam(input logic [7:0] y);
    for (int n = 0; n < 64; n++) begin
      oam[4*n]     = y;
      oam[4*n + 1] = 8'($urandom);
      oam[4*n + 2] = 8'($urandom);
      oam[4*n + 3] = 8'($urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_wren"},     int'(bus.O_sec_wren), 0);
    chk({pfx, "_busy"},     int'(bus.O_busy),     0);
    chk({pfx, "_done"},     int'(bus.O_done),     0);
    chk({pfx, "_count"},    int'(bus.O_count),    0);
    chk({pfx, "_ovf"},      int'(bus.O_overflow), 0);
    chk({pfx, "_s0"},       int'(bus.O_sprite0),  0);
    chk({pfx, "_oam_addr"}, int'(bus.O_oam_addr), 0);
    chk({pfx, "_sec_addr"}, int'(bus.O_sec_addr), 0);
    chk({pfx, "_sec_data"}, int'(bus.O_sec_data), 0);
  endtask

  // mode 0: plain run; mode 1: extra start pulse during COPY;
  // mode 2: reset pulse during the second COPY cycle (run is abandoned).
  task automatic run_scan(input logic [7:0] sl, input bit tl, input int mode, input string name);
    int  cyc;
    int  stray;
    bit  done_seen;
    bit  injected;
    wr_t w;

    build_expect(int'(sl), tl);
    for (int a = 0; a < 32; a++) sec_mem[a] = 8'h00;

    @(negedge clk);
    bus.I_scanline = sl;
    bus.I_tall     = tl;
    bus.I_start    = 1'b1;
    @(negedge clk);
    bus.I_start    = 1'b0;
    // Inputs change mid-run; the latched copies must be used.
    bus.I_scanline = ~sl;
    bus.I_tall     = ~tl;

    cyc       = 1;
    done_seen = 1'b0;
    injected  = 1'b0;
    while (!done_seen && cyc < 400) begin
      bus.I_start = 1'b0;
      if (bus.O_sec_wren) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", int'(bus.O_sec_addr) + 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", int'(bus.O_sec_addr), int'(w.addr));
          chk("wr_data", int'(bus.O_sec_data), int'(w.data));
        end
        sec_mem[bus.O_sec_addr] = bus.O_sec_data;
        if (mode == 1 && !injected && cyc > 32 && bus.O_sec_addr[1:0] == 2'd1) begin
          bus.I_start = 1'b1;
          injected    = 1'b1;
        end
        if (mode == 2 && !injected && cyc > 32 && bus.O_sec_addr[1:0] == 2'd2) begin
          rst = 1'b1;
          #1;
          chk_reset_outputs("mid_rst");
          exp_q.delete();
          @(negedge clk);
          rst   = 1'b0;
          stray = 0;
          repeat (6) begin
            @(negedge clk);
            if (bus.O_busy || bus.O_sec_wren) stray++;
          end
          chk("post_rst_idle", stray, 0);
          $display("run %s: reset applied at cycle %0d", name, cyc);
          return;
        end
      end
      if (bus.O_done) begin
        done_seen = 1'b1;
        chk("done_cycle", cyc, exp_cycles);
      end
      @(negedge clk);
      cyc++;
    end
    bus.I_start = 1'b0;

    if (!done_seen) chk("done_timeout", 0, 1);
    chk("done_width",   int'(bus.O_done), 0);
    chk("busy_after",   int'(bus.O_busy), 0);
    chk("writes_left",  exp_q.size(),     0);
    chk("count",        int'(bus.O_count),    exp_count);
    chk("overflow",     int'(bus.O_overflow), exp_ovf);
    chk("sprite0",      int'(bus.O_sprite0),  exp_s0);
    for (int a = 0; a < 32; a++) chk("sec_mem", int'(sec_mem[a]), int'(exp_mem[a]));
    $display("run %s: sl=%0d tall=%0d count=%0d ovf=%0d s0=%0d cycles=%0d",
             name, sl, tl, bus.O_count, bus.O_overflow, bus.O_sprite0, cyc - 1);
  endtask

  initial begin
    bus.I_start    = 1'b0;
    bus.I_scanline = 8'd0;
    bus.I_tall     = 1'b0;
    fill_oam(8'hFF);

    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(bus.O_busy), 0);

    // Nothing in range
    fill_oam(8'hFF);
    run_scan(8'd100, 1'b0, 0, "none");
    chk("none_latency", exp_cycles, 97);

    // Single sprite at index 5
    fill_oam(8'hFF);
    oam[20] = 8'd96; oam[21] = 8'h12; oam[22] = 8'h41; oam[23] = 8'h30;
    run_scan(8'd100, 1'b0, 0, "single");
    chk("single_b0", int'(sec_mem[0]), 96);
    chk("single_b1", int'(sec_mem[1]), 'h12);
    chk("single_b2", int'(sec_mem[2]), 'h41);
    chk("single_b3", int'(sec_mem[3]), 'h30);
    chk("single_b4", int'(sec_mem[4]), 'hFF);
    chk("single_cnt", int'(bus.O_count), 1);

    // Height boundary
    fill_oam(8'hFF);
    oam[0] = 8'd92;
    run_scan(8'd100, 1'b0, 0, "y92_short");
    chk("y92_short_cnt", int'(bus.O_count), 0);
    run_scan(8'd100, 1'b1, 0, "y92_tall");
    chk("y92_tall_cnt", int'(bus.O_count), 1);
    chk("y92_tall_s0", int'(bus.O_sprite0), 1);
    oam[0] = 8'd101;
    run_scan(8'd100, 1'b0, 0, "y101_short");
    chk("y101_short_cnt", int'(bus.O_count), 0);
    run_scan(8'd100, 1'b1, 0, "y101_tall");
    chk("y101_tall_cnt", int'(bus.O_count), 0);

    // Overflow: ten sprites on the line
    fill_oam(8'hFF);
    for (int n = 0; n < 10; n++) oam[4*n] = 8'd100;
    run_scan(8'd100, 1'b0, 0, "overflow");
    chk("ovf_cnt",  int'(bus.O_count), 8);
    chk("ovf_flag", int'(bus.O_overflow), 1);

    // Last sprite in range must finish its copy
    fill_oam(8'hFF);
    oam[252] = 8'd95;
    run_scan(8'd100, 1'b1, 0, "last");
    chk("last_cnt", int'(bus.O_count), 1);

    // Randomised OAM contents
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 64; n++) oam[4*n] = 8'($urandom_range(70, 130));
      run_scan(8'($urandom_range(90, 110)), 1'($urandom_range(0, 1)), 0, "random");
    end

    // Start pulse during COPY must be ignored
    fill_oam(8'hFF);
    for (int n = 0; n < 10; n++) oam[4*n + 8] = 8'd98;
    run_scan(8'd100, 1'b0, 1, "start_in_copy");

    // Reset during COPY, then a clean run
    fill_oam(8'hFF);
    oam[20] = 8'd96; oam[21] = 8'h12; oam[22] = 8'h41; oam[23] = 8'h30;
    run_scan(8'd100, 1'b0, 2, "reset_in_copy");
    run_scan(8'd100, 1'b0, 0, "after_reset");
    chk("after_reset_cnt", int'(bus.O_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
